// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - state encoding and counter width helper for the sequential restoring divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step
module seq_div_step #(
    parameter int m = 12
) (
    input  logic [m:0]   p,
    input  logic         din,
    input  logic [m-1:0] b,
    output logic [m:0]   p_next,
    output logic         qbit
);

    logic [m:0] t;
    logic       ge;

    // A set p[m] means the full shifted value exceeds any m-bit divisor.
    assign t      = {p[m-1:0], din};
    assign ge     = p[m] | (t >= {1'b0, b});
    assign p_next = ge ? (t - {1'b0, b}) : t;
    assign qbit   = ge;

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - 2m/m sequential restoring divider; SEQ_DIV_EXC_EN enables dz/ovf early exit
module seq_div
    import seq_div_pkg::*;
#(
    parameter int m = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*m-1:0] a,
    input  logic [m-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [m-1:0]   q,
    output logic [m-1:0]   r,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = cnt_width(m);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [m:0]    p, p_nx;
    logic [m-1:0]  qs, b_q;
    logic          qbit;
    logic          last;
    logic          exc_dz, exc_ovf;

`ifdef SEQ_DIV_EXC_EN
    assign exc_dz  = (b == '0);
    assign exc_ovf = !exc_dz && (a[2*m-1:m] >= b);
`else
    assign exc_dz  = 1'b0;
    assign exc_ovf = 1'b0;
`endif

    assign last = (cnt == CW'(m - 1));
    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

    seq_div_step #(.m(m)) u_step (
        .p      (p),
        .din    (qs[m-1]),
        .b      (b_q),
        .p_next (p_nx),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (exc_dz || exc_ovf) ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Results and flags are only written on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            p   <= '0;
            qs  <= '0;
            b_q <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p   <= {1'b0, a[2*m-1:m]};
                        qs  <= a[m-1:0];
                        b_q <= b;
                        cnt <= '0;
                        if (exc_dz) begin
                            q   <= '1;
                            r   <= a[m-1:0];
                            dz  <= 1'b1;
                            ovf <= 1'b0;
                        end else if (exc_ovf) begin
                            q   <= '1;
                            r   <= '0;
                            dz  <= 1'b0;
                            ovf <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p   <= p_nx;
                    qs  <= {qs[m-2:0], qbit};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        q   <= {qs[m-2:0], qbit};
                        r   <= p_nx[m-1:0];
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div at m=12
module tb_seq_div;

    localparam int M = 12;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2*M-1:0] a;
    logic [M-1:0]  b;
    logic          busy, done, dz, ovf;
    logic [M-1:0]  q, r;

    int passed = 0;
    int total  = 0;
    int lat;
    logic busy_bad;
    logic done_seen;

    seq_div #(.m(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then count cycles until done (bounded).
    task automatic run(input logic [2*M-1:0] aa, input logic [M-1:0] bb);
        a = aa;
        b = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            tick();
            lat++;
        end
        if (!busy) busy_bad = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_flags", {30'd0, dz, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        run(24'd1000, 12'd7);
        chk("basic_lat", 32'(lat), 32'd12);
        chk("basic_busy", 32'(busy_bad), 32'd0);
        chk("basic_q", 32'(q), 32'd142);
        chk("basic_r", 32'(r), 32'd6);
        chk("basic_flags", {30'd0, dz, ovf}, 32'd0);
        tick();
        chk("basic_done_width", 32'(done), 32'd0);
        chk("basic_idle_busy", 32'(busy), 32'd0);
        chk("basic_q_held", 32'(q), 32'd142);

        run(24'hFFEFFF, 12'hFFF);
        chk("max_q", 32'(q), 32'hFFF);
        chk("max_r", 32'(r), 32'hFFE);
        chk("max_ovf", 32'(ovf), 32'd0);
        tick();

        run(24'h123456, 12'hABC);
        chk("mix_q", 32'(q), 32'h1B2);
        chk("mix_r", 32'(r), 32'h19E);
        tick();

        run(24'd12345, 12'd100);
        chk("dec_q", 32'(q), 32'd123);
        chk("dec_r", 32'(r), 32'd45);
        tick();

`ifdef SEQ_DIV_EXC_EN
        run(24'd5, 12'd0);
        chk("dz_lat", 32'(lat), 32'd0);
        chk("dz_flags", {30'd0, dz, ovf}, 32'd2);
        chk("dz_q", 32'(q), 32'hFFF);
        chk("dz_r", 32'(r), 32'd5);
        tick();
        run(24'h0FFFFF, 12'd16);
        chk("ovf_lat", 32'(lat), 32'd0);
        chk("ovf_flags", {30'd0, dz, ovf}, 32'd1);
        chk("ovf_q", 32'(q), 32'hFFF);
        chk("ovf_r", 32'(r), 32'd0);
        tick();
        run(24'd100, 12'd10);
        chk("clr_flags", {30'd0, dz, ovf}, 32'd0);
        chk("clr_q", 32'(q), 32'd10);
        tick();
`else
        run(24'd5, 12'd0);
        chk("nodz_lat", 32'(lat), 32'd12);
        chk("nodz_flags", {30'd0, dz, ovf}, 32'd0);
        tick();
`endif

        // start pulses during CALC and during DONE must both be ignored
        a = 24'd1000;
        b = 12'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 24'd100;
        b = 12'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hs_busy_mid", 32'(busy), 32'd1);
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("hs_lat", 32'(lat), 32'd12);
        chk("hs_q", 32'(q), 32'd142);
        chk("hs_r", 32'(r), 32'd6);
        a = 24'd50;
        b = 12'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hs_done_start_ign", 32'(busy), 32'd0);
        tick();
        chk("hs_still_idle", 32'(busy), 32'd0);
        run(24'd100, 12'd10);
        chk("hs_next_q", 32'(q), 32'd10);
        chk("hs_next_r", 32'(r), 32'd0);
        tick();

        // asynchronous reset at CALC step 5
        run(24'd1000, 12'd7);
        tick();
        a = 24'd1000;
        b = 12'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_r", 32'(r), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_seen = 1'b1;
        end
        chk("arst_no_done", 32'(done_seen), 32'd0);
        rst_n = 1'b1;
        tick();
        run(24'd100, 12'd10);
        chk("arst_after_lat", 32'(lat), 32'd12);
        chk("arst_after_q", 32'(q), 32'd10);
        chk("arst_after_r", 32'(r), 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Parameterized sequential restoring divider: divides a 2m-bit dividend by an m-bit divisor, producing an m-bit quotient and an m-bit remainder, one quotient bit per clock. It is the inverse of the team's m×m→2m sequential shift-add multiplier. It sits beside that multiplier in the DDS arithmetic datapath, for example for frequency-word normalisation, and uses a start/busy/done handshake.

## Interface
- `m`, default 12: width of divisor, quotient and remainder; the dividend is 2m bits wide.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `a`, input, 2m: dividend. Captured on the accepting edge.
- `b`, input, m: divisor. Captured on the accepting edge.
- `busy`, output, 1: high in CALC and DONE.
- `done`, output, 1: one-cycle pulse; `q`/`r`/flags are valid while it is high and are held afterwards.
- `q`, output, m: quotient.
- `r`, output, m: remainder.
- `dz`, output, 1: divide-by-zero flag.
- `ovf`, output, 1: quotient-overflow flag.

## Operation
- States: IDLE, CALC, DONE. Encoding is 2 bits; the fourth code is illegal and returns to IDLE.
- IDLE, `start`=1 at edge N:
  - Capture `a` and `b`.
  - Partial remainder P (m+1 bits) = a[2m-1:m]; shift register Qs = a[m-1:0]; counter `cnt` (clog2(m)+1 bits) = 0.
  - Go to CALC, or straight to DONE under the exception rules.
- CALC, each edge:
  - T = {P[m-1:0], Qs[m-1]}.
  - If T ≥ {1'b0,b}: P = T − b and shift a 1 into Qs; else P = T and shift a 0 into Qs.
  - `cnt` increments. On the edge completing the m-th step, register q = Qs and r = P[m-1:0], then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` while busy is ignored, not queued. `start` in the DONE cycle is also ignored.
- Exceptions (only with the macro enabled):
  - b = 0: dz=1, q = all ones, r = a[m-1:0].
  - Otherwise, a[2m-1:m] ≥ b: ovf=1, q = all ones, r = 0.
  - dz has priority over ovf. Both are cleared on the next accepted start.
- Arithmetic is unsigned only. The subtract compare is m+1 bits wide so it never wraps.

## Timing
- Reset: all outputs 0, state IDLE, `cnt`=0, P=0, Qs=0.
- Reset mid-operation abandons the division immediately. No `done` is produced and the outputs read 0.
- Normal latency: start accepted at edge N → `done` high in the cycle following edge N+m.
- Exception latency: `done` high in the cycle following edge N.
- Back-to-back: the earliest next accept is at edge N+m+2, giving a throughput of one division per m+2 clocks.
- `q`, `r`, `dz` and `ovf` are registered. They change only on the edge that enters DONE, or on reset.

## Configuration
- `SEQ_DIV_EXC_EN`, defined:
  - dz/ovf detection and the early exit to DONE are built in.
- `SEQ_DIV_EXC_EN`, undefined:
  - No detection logic; `dz` and `ovf` are tied to 0; every division takes the full m-cycle CALC path.
  - q and r are deterministic for exceptional operands but are not specified.

## Structure
- Package `seq_div_pkg` holds:
  - the state encoding constants IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - a width helper function for `cnt`.
- Sub-module `seq_div_step`: combinational single restoring step.
  - Inputs: P, next dividend bit, b.
  - Outputs: next P, quotient bit.
  - Instanced once inside `seq_div`.

## Test plan
All scenarios use m=12.
- Basic: a=1000, b=7 → q=142, r=6, `done` m=12 cycles after the start edge, one cycle wide.
- Max valid: a=24'hFFEFFF, b=12'hFFF → q=12'hFFF, r=12'hFFE, ovf=0.
- Exceptions (macro on):
  - a=5, b=0 → dz=1, q=12'hFFF, r=5, `done` 1 cycle after start.
  - a=24'h0FFFFF, b=16 → ovf=1, q=12'hFFF, r=0.
- Handshake: pulse `start` with new operands mid-CALC → ignored; the first result is unchanged; busy is high from accept through DONE; the next start is accepted in IDLE.
- Reset: assert `rst_n`=0 asynchronously at CALC step 5 → outputs 0 immediately, no `done`; after release, a=100, b=10 → q=10, r=0.
